// File: rtl/wallace_pkg.sv
// Shared types and helpers for the Wallace / CLA elastic pipeline stages.
package wallace_pkg;
   localparam int DEF_DATA_W = 8;

   typedef logic [DEF_DATA_W-1:0] lane_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } slot_state_t;

   function automatic int occ_w(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

   function automatic logic [1:0] slot_cnt(input slot_state_t s);
      case (s)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction
endpackage

// File: rtl/wallace_pipe_stage_slot.sv
// One elastic stage: main + skid register with a registered ready, so the
// upstream ready never sees the downstream ready combinationally.
module pipe_skid_slot
   import wallace_pkg::*;
#(
   parameter int W = 512
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   cnt_nxt
);
   slot_state_t  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         ready_q, ready_d;
   logic         acc, drn;

   always_comb begin
      acc     = in_valid & ready_q & ~flush;
      drn     = (state_q != EMPTY) & out_ready & ~flush;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (acc) begin
               state_d = ONE;
               main_d  = in_data;
            end
            ONE: begin
               if (acc && drn) begin
                  main_d = in_data;
               end else if (acc) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (drn) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (drn) begin
               state_d = ONE;
               main_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
      ready_d = (state_d != TWO);
      cnt_nxt = slot_cnt(state_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   // Flush masks the handshake in the same cycle it is applied.
   assign in_ready  = ready_q & ~flush;
   assign out_valid = (state_q != EMPTY) & ~flush;
   assign out_data  = main_q;
endmodule

// File: rtl/wallace_pipe_stage.sv
// DEPTH-deep chain of back-pressurable skid slots carrying LANES x DATA_W
// beats, with synchronous flush and a registered occupancy count.
module wallace_pipe_stage
   import wallace_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int LANES  = 64,
   parameter  int DEPTH  = 2,
   localparam int W      = LANES * DATA_W,
   localparam int OCC_W  = occ_w(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES-1:0][DATA_W-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0][DATA_W-1:0]  out_data,
   output logic [OCC_W-1:0]              occ
);
   logic [DEPTH:0]            vld, rdy;
   logic [DEPTH:0][W-1:0]     dat;
   logic [DEPTH-1:0][1:0]     cnt_nxt;
   logic [OCC_W-1:0]          occ_q, occ_d;

   assign vld[0]     = in_valid;
   assign dat[0]     = in_data;
   assign in_ready   = rdy[0];
   assign rdy[DEPTH] = out_ready;
   assign out_valid  = vld[DEPTH];
   assign out_data   = dat[DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      pipe_skid_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (vld[i]),
         .in_ready  (rdy[i]),
         .in_data   (dat[i]),
         .out_valid (vld[i+1]),
         .out_ready (rdy[i+1]),
         .out_data  (dat[i+1]),
         .cnt_nxt   (cnt_nxt[i])
      );
   end

   // Summing next-state counts keeps occ aligned with the slot state flops.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(cnt_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) occ_q <= '0;
      else      occ_q <= occ_d;
   end

   assign occ = occ_q;
endmodule

// File: tb/tb_wallace_pipe_stage.sv
// Directed + randomized bench: a queue scoreboard models the pipe as an
// order-preserving store whose occupancy equals beats accepted minus beats drained.
module tb_wallace_pipe_stage;
   import wallace_pkg::*;

   localparam int WA = 512;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic                a_flush = 0, a_in_valid = 0, a_out_ready = 0;
   logic                a_in_ready, a_out_valid;
   logic [63:0][7:0]    a_in_data = '0, a_out_data;
   logic [2:0]          a_occ;

   logic                b_flush = 0, b_in_valid = 0, b_out_ready = 0;
   logic                b_in_ready, b_out_valid;
   lane_t               b_in_data = '0, b_out_data;
   logic [1:0]          b_occ;

   wallace_pipe_stage #(.DATA_W(8), .LANES(64), .DEPTH(2)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .occ(a_occ));

   wallace_pipe_stage #(.DATA_W(8), .LANES(1), .DEPTH(1)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .occ(b_occ));

   int checks = 0;
   int errors = 0;
   logic [WA-1:0] qa[$];
   logic [7:0]    qb[$];

   task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WA-1:0] rnd512();
      logic [WA-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: capture handshakes before the edge, then update the model.
   task automatic tick(output bit acc_a, output bit acc_b);
      logic [WA-1:0] oda, ida;
      logic [7:0]    odb, idb;
      bit            da, db, fa, fb;
      acc_a = a_in_valid && a_in_ready;  da = a_out_valid && a_out_ready;
      oda = a_out_data; ida = a_in_data; fa = a_flush;
      acc_b = b_in_valid && b_in_ready;  db = b_out_valid && b_out_ready;
      odb = b_out_data; idb = b_in_data; fb = b_flush;
      @(posedge clk); #1;
      if (fa) qa.delete();
      else begin
         if (da) begin
            chk("a_out_has_beat", WA'(qa.size() != 0), WA'(1));
            if (qa.size() != 0) chk("a_data", oda, qa.pop_front());
         end
         if (acc_a) qa.push_back(ida);
      end
      if (fb) qb.delete();
      else begin
         if (db) begin
            chk("b_out_has_beat", WA'(qb.size() != 0), WA'(1));
            if (qb.size() != 0) chk("b_data", WA'(odb), WA'(qb.pop_front()));
         end
         if (acc_b) qb.push_back(idb);
      end
      chk("a_occ", WA'(a_occ), WA'(qa.size()));
      chk("b_occ", WA'(b_occ), WA'(qb.size()));
      chk("b_occ_le2", WA'(b_occ <= 2), WA'(1));
   endtask

   initial begin
      bit aa, ab, got;
      int n, bcnt;
      logic [WA-1:0] marker;

      // Reset state
      #12;
      chk("rst_in_ready", WA'(a_in_ready), WA'(0));
      chk("rst_out_valid", WA'(a_out_valid), WA'(0));
      chk("rst_out_data", WA'(a_out_data), WA'(0));
      chk("rst_occ", WA'(a_occ), WA'(0));
      rst = 1;
      tick(aa, ab);
      chk("ready_after_rst", WA'(a_in_ready), WA'(1));

      // Unstalled stream, beats 0x01..0x10 in lane 0
      a_out_ready = 1; a_in_valid = 1; a_in_data = WA'(1);
      tick(aa, ab);
      chk("stream_acc1", WA'(aa), WA'(1));
      chk("lat_valid_early", WA'(a_out_valid), WA'(0));
      a_in_data = WA'(2);
      tick(aa, ab);
      chk("lat_valid", WA'(a_out_valid), WA'(1));
      chk("lat_data", WA'(a_out_data), WA'(1));
      for (int k = 3; k <= 16; k++) begin
         a_in_data = WA'(k);
         tick(aa, ab);
         chk("stream_acc", WA'(aa), WA'(1));
         chk("stream_valid", WA'(a_out_valid), WA'(1));
      end
      chk("stream_occ", WA'(a_occ), WA'(2));
      a_in_valid = 0;
      for (int k = 0; k < 4; k++) tick(aa, ab);
      chk("stream_drained", WA'(qa.size()), WA'(0));

      // Full back-pressure: A..D fill, E refused, then ordered drain
      a_out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         a_in_valid = 1; a_in_data = rnd512(); a_in_data[0] = 8'hA0 + 8'(k);
         got = 0;
         for (int t = 0; t < 4 && !got; t++) begin tick(aa, ab); got = aa; end
         chk("bp_acc", WA'(got), WA'(1));
      end
      chk("bp_full_ready", WA'(a_in_ready), WA'(0));
      chk("bp_full_occ", WA'(a_occ), WA'(4));
      a_in_data = rnd512(); a_in_data[0] = 8'hE0;
      for (int k = 0; k < 3; k++) begin
         tick(aa, ab);
         chk("bp_e_refused", WA'(aa), WA'(0));
      end
      a_out_ready = 1; #1;
      chk("no_comb_ready", WA'(a_in_ready), WA'(0));
      got = 0;
      for (int t = 0; t < 20; t++) begin
         tick(aa, ab);
         if (aa) begin got = 1; a_in_valid = 0; end
      end
      chk("bp_e_accepted", WA'(got), WA'(1));
      chk("bp_drained", WA'(qa.size()), WA'(0));

      // Flush with occ=3 and a beat offered on the same edge
      a_out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         a_in_valid = 1; a_in_data = rnd512();
         tick(aa, ab);
      end
      chk("fl_occ3", WA'(a_occ), WA'(3));
      marker = rnd512(); a_in_data = marker; a_flush = 1; #1;
      chk("fl_in_ready", WA'(a_in_ready), WA'(0));
      chk("fl_out_valid", WA'(a_out_valid), WA'(0));
      tick(aa, ab);
      a_flush = 0; a_in_valid = 0; #1;
      chk("fl_after_occ", WA'(a_occ), WA'(0));
      chk("fl_after_valid", WA'(a_out_valid), WA'(0));
      a_out_ready = 1;
      for (int k = 0; k < 4; k++) tick(aa, ab);
      chk("fl_nothing_left", WA'(qa.size()), WA'(0));

      // Asynchronous reset between edges, mid-stream
      for (int k = 0; k < 6; k++) begin
         a_in_valid = 1; a_in_data = rnd512();
         tick(aa, ab);
      end
      #2 rst = 0; #1;
      chk("arst_out_valid", WA'(a_out_valid), WA'(0));
      chk("arst_out_data", WA'(a_out_data), WA'(0));
      chk("arst_occ", WA'(a_occ), WA'(0));
      chk("arst_in_ready", WA'(a_in_ready), WA'(0));
      qa.delete(); qb.delete();
      #1 rst = 1;
      for (int k = 0; k < 5; k++) begin
         a_in_data = rnd512();
         tick(aa, ab);
      end
      a_in_valid = 0;
      for (int k = 0; k < 6; k++) tick(aa, ab);
      chk("arst_restart_drained", WA'(qa.size()), WA'(0));

      // Random traffic on A; DEPTH=1 corner on B with alternating out_ready
      n = 0; bcnt = 0;
      b_in_valid = 1; b_in_data = 8'(bcnt);
      for (int c = 0; c < 60000 && n < 10000; c++) begin
         a_in_valid  = ($urandom_range(3) != 0);
         a_out_ready = ($urandom_range(1) != 0);
         a_in_data   = rnd512();
         b_out_ready = c[0];
         if (c % 16 == 0) begin
            got = a_in_ready;
            a_out_ready = ~a_out_ready; #1;
            chk("rand_no_comb_ready", WA'(a_in_ready), WA'(got));
            a_out_ready = ~a_out_ready;
         end
         tick(aa, ab);
         if (aa) n++;
         if (ab) begin bcnt++; b_in_data = 8'(bcnt); end
      end
      chk("rand_beats", WA'(n), WA'(10000));
      a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
      for (int k = 0; k < 8; k++) tick(aa, ab);
      chk("rand_a_drained", WA'(qa.size()), WA'(0));
      chk("rand_b_drained", WA'(qb.size()), WA'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
